// File: rtl/hydra_pll_ctrl.sv
// hydra_pll_ctrl
// Sequencer and supervisor for the SB_PLL40 wrapper. It pulses PLL reset,
// waits for a filtered LOCK with a per-attempt timeout, and gives up after
// MAX_RETRIES failed attempts. It also applies host dynamic-delay changes
// through a REQ/ACK handshake. READY is the fabric-wide "clock good" qualifier.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// HOLD      | PLL_RESETB low for RESET_CYCLES cycles
// WAIT_LOCK | PLL released; wait for LOCK_STABLE clean lock cycles or timeout
// RUN       | locked; READY high from the second cycle; watch for lock loss
// APPLY     | one cycle: new delay driven, ACK pulsed, then back to WAIT_LOCK
// FAULT     | retries exhausted; PLL held in reset until RESET
//
// Ports:
//   CLK, RESET       reference clock, async active-high reset
//   PLL_RESETB       to PLL RESETB (active low)
//   PLL_LOCK         raw PLL LOCK, asynchronous to CLK
//   PLL_DELAY        to PLL DYNAMICDELAY
//   DELAY_REQ/VAL    host delay request; VAL stable while REQ is high
//   DELAY_ACK        one-cycle pulse when VAL has been applied
//   READY            locked and filtered
//   FAULT            sticky, lock attempts exhausted
//   RETRY_CNT        failed attempts in the current sequence
//   LOSS_CNT         saturating count of lock losses while in RUN

module hydra_pll_ctrl #(
    parameter int unsigned        DELAY_W      = 8,
    parameter logic [DELAY_W-1:0] INIT_DELAY   = '0,
    parameter int unsigned        RESET_CYCLES = 16,
    parameter int unsigned        LOCK_STABLE  = 64,
    parameter int unsigned        LOCK_TIMEOUT = 4096,
    parameter int unsigned        MAX_RETRIES  = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic               PLL_RESETB,
    input  logic               PLL_LOCK,
    output logic [DELAY_W-1:0] PLL_DELAY,
    input  logic               DELAY_REQ,
    input  logic [DELAY_W-1:0] DELAY_VAL,
    output logic               DELAY_ACK,
    output logic               READY,
    output logic               FAULT,
    output logic [1:0]         RETRY_CNT,
    output logic [7:0]         LOSS_CNT
);

    localparam int HOLD_W = $clog2(RESET_CYCLES) + 1;
    localparam int STAB_W = $clog2(LOCK_STABLE) + 1;
    localparam int TOUT_W = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_DONE   = STAB_W'(LOCK_STABLE);
    localparam logic [TOUT_W-1:0] TOUT_DONE   = TOUT_W'(LOCK_TIMEOUT);
    localparam logic [1:0]        RETRY_LIMIT = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_RUN,
        ST_APPLY,
        ST_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STAB_W-1:0]   stable_q, stable_d;
    logic [TOUT_W-1:0]   timeout_q, timeout_d;
    logic [1:0]          retry_q, retry_d, retry_inc;
    logic [7:0]          loss_q, loss_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic                armed_q, armed_d;
    logic                lock_meta_q, lock_meta_d;
    logic                lock_s_q, lock_s_d;
    logic                resetb_q, resetb_d;
    logic                ack_q, ack_d;
    logic                ready_q, ready_d;
    logic                fault_q, fault_d;
    logic                accept;

    always_comb begin
        state_d     = state_q;
        hold_d      = '0;
        stable_d    = '0;
        timeout_d   = '0;
        retry_d     = retry_q;
        loss_d      = loss_q;
        delay_d     = delay_q;
        lock_meta_d = PLL_LOCK;
        lock_s_d    = lock_meta_q;
        retry_inc   = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
        accept      = DELAY_REQ && armed_q;

        // Re-arm only after the host has dropped REQ following an ACK.
        armed_d = armed_q;
        if (state_q == ST_APPLY) begin
            armed_d = 1'b0;
        end else if (!DELAY_REQ) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                timeout_d = timeout_q + TOUT_W'(1);
                stable_d  = lock_s_q ? stable_q + STAB_W'(1) : '0;
                // Stable lock takes priority over a coincident timeout.
                if (stable_d == STAB_DONE) begin
                    state_d = ST_RUN;
                    retry_d = 2'd0;
                end else if (timeout_d == TOUT_DONE) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
                end
            end
            ST_RUN: begin
                // Lock loss wins over a request; the request stays pending.
                if (!lock_s_q) begin
                    state_d = ST_HOLD;
                    loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end else if (accept) begin
                    state_d = ST_APPLY;
                    delay_d = DELAY_VAL;
                end
            end
            ST_APPLY: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (state_d != ST_WAIT_LOCK) begin
            stable_d  = '0;
            timeout_d = '0;
        end

        // Outputs are registered from the next state so they line up with it.
        resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_RUN) || (state_d == ST_APPLY);
        ack_d    = (state_d == ST_APPLY);
        ready_d  = (state_q == ST_RUN) && (state_d == ST_RUN);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_HOLD;
            hold_q      <= '0;
            stable_q    <= '0;
            timeout_q   <= '0;
            retry_q     <= 2'd0;
            loss_q      <= 8'd0;
            delay_q     <= INIT_DELAY;
            armed_q     <= 1'b1;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            resetb_q    <= 1'b0;
            ack_q       <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stable_q    <= stable_d;
            timeout_q   <= timeout_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            delay_q     <= delay_d;
            armed_q     <= armed_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            resetb_q    <= resetb_d;
            ack_q       <= ack_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign PLL_RESETB = resetb_q;
    assign PLL_DELAY  = delay_q;
    assign DELAY_ACK  = ack_q;
    assign READY      = ready_q;
    assign FAULT      = fault_q;
    assign RETRY_CNT  = retry_q;
    assign LOSS_CNT   = loss_q;

endmodule

// File: tb/tb_hydra_pll_ctrl.sv
// Testbench for hydra_pll_ctrl: directed scenarios plus a randomized soak,
// every cycle compared against a phase/age reference model.

module tb_hydra_pll_ctrl;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 64;
    localparam int MR = 2;
    localparam logic [7:0] INIT = 8'h05;

    logic       CLK       = 1'b0;
    logic       RESET     = 1'b1;
    logic       PLL_LOCK  = 1'b0;
    logic       DELAY_REQ = 1'b0;
    logic [7:0] DELAY_VAL = 8'h00;
    logic       PLL_RESETB;
    logic [7:0] PLL_DELAY;
    logic       DELAY_ACK;
    logic       READY;
    logic       FAULT;
    logic [1:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;

    int n_assert = 0;
    int n_fail   = 0;

    hydra_pll_ctrl #(
        .DELAY_W     (8),
        .INIT_DELAY  (INIT),
        .RESET_CYCLES(RC),
        .LOCK_STABLE (LS),
        .LOCK_TIMEOUT(LT),
        .MAX_RETRIES (MR)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PLL_RESETB(PLL_RESETB),
        .PLL_LOCK  (PLL_LOCK),
        .PLL_DELAY (PLL_DELAY),
        .DELAY_REQ (DELAY_REQ),
        .DELAY_VAL (DELAY_VAL),
        .DELAY_ACK (DELAY_ACK),
        .READY     (READY),
        .FAULT     (FAULT),
        .RETRY_CNT (RETRY_CNT),
        .LOSS_CNT  (LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: a phase plus the number of cycles spent in it.
    localparam int PH_HOLD  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_APPLY = 3;
    localparam int PH_FAULT = 4;

    int         m_phase   = PH_HOLD;
    int         m_age     = 0;
    int         m_run     = 0;
    int         m_retries = 0;
    int         m_loss    = 0;
    logic       m_s1      = 1'b0;
    logic       m_s2      = 1'b0;
    logic       m_armed   = 1'b1;
    logic [7:0] m_delay   = INIT;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_phase   <= PH_HOLD;
            m_age     <= 0;
            m_run     <= 0;
            m_retries <= 0;
            m_loss    <= 0;
            m_s1      <= 1'b0;
            m_s2      <= 1'b0;
            m_armed   <= 1'b1;
            m_delay   <= INIT;
        end else begin
            m_s1  <= PLL_LOCK;
            m_s2  <= m_s1;
            m_age <= m_age + 1;
            if (m_phase == PH_APPLY) m_armed <= 1'b0;
            else if (!DELAY_REQ)     m_armed <= 1'b1;
            case (m_phase)
                PH_HOLD: if (m_age + 1 >= RC) begin
                    m_phase <= PH_WAIT; m_age <= 0; m_run <= 0;
                end
                PH_WAIT: begin
                    m_run <= m_s2 ? m_run + 1 : 0;
                    if (m_s2 && m_run + 1 >= LS) begin
                        m_phase <= PH_RUN; m_age <= 0; m_retries <= 0;
                    end else if (m_age + 1 >= LT) begin
                        m_retries <= (m_retries + 1 > 3) ? 3 : m_retries + 1;
                        m_phase   <= (m_retries + 1 == MR) ? PH_FAULT : PH_HOLD;
                        m_age     <= 0;
                    end
                end
                PH_RUN: begin
                    if (!m_s2) begin
                        m_phase <= PH_HOLD; m_age <= 0;
                        m_loss  <= (m_loss < 255) ? m_loss + 1 : 255;
                    end else if (DELAY_REQ && m_armed) begin
                        m_phase <= PH_APPLY; m_age <= 0; m_delay <= DELAY_VAL;
                    end
                end
                PH_APPLY: begin
                    m_phase <= PH_WAIT; m_age <= 0; m_run <= 0;
                end
                default: ;
            endcase
        end
    end

    logic m_resetb, m_ready, m_ack, m_fault;
    assign m_resetb = (m_phase == PH_WAIT) || (m_phase == PH_RUN) || (m_phase == PH_APPLY);
    assign m_ready  = (m_phase == PH_RUN) && (m_age >= 1);
    assign m_ack    = (m_phase == PH_APPLY);
    assign m_fault  = (m_phase == PH_FAULT);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("model_resetb", 32'(PLL_RESETB), 32'(m_resetb));
        chk("model_delay",  32'(PLL_DELAY),  32'(m_delay));
        chk("model_ack",    32'(DELAY_ACK),  32'(m_ack));
        chk("model_ready",  32'(READY),      32'(m_ready));
        chk("model_fault",  32'(FAULT),      32'(m_fault));
        chk("model_retry",  32'(RETRY_CNT),  32'(m_retries));
        chk("model_loss",   32'(LOSS_CNT),   32'(m_loss));
    endtask

    task automatic tick();
        @(negedge CLK);
        check_all();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int limit, input logic lvl);
        for (int i = 0; i < limit && READY !== lvl; i++) tick();
        chk(tag, 32'(READY), 32'(lvl));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_resetb"}, 32'(PLL_RESETB), 32'd0);
        chk({tag, "_delay"},  32'(PLL_DELAY),  32'(INIT));
        chk({tag, "_ack"},    32'(DELAY_ACK),  32'd0);
        chk({tag, "_ready"},  32'(READY),      32'd0);
        chk({tag, "_fault"},  32'(FAULT),      32'd0);
        chk({tag, "_retry"},  32'(RETRY_CNT),  32'd0);
        chk({tag, "_loss"},   32'(LOSS_CNT),   32'd0);
    endtask

    initial begin
        int         cnt;
        logic       seen;
        logic [7:0] v;

        // Reset values
        tick();
        tick();
        check_reset_vals("rst");

        // Normal lock
        RESET = 1'b0;
        cnt   = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (PLL_RESETB === 1'b1) break;
            cnt++;
        end
        chk("hold_len", 32'(cnt), 32'(RC));
        PLL_LOCK = 1'b1;
        cnt      = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cnt++;
            if (READY === 1'b1) break;
        end
        chk("lock_to_ready", 32'(cnt), 32'd11);
        chk("lock_delay", 32'(PLL_DELAY), 32'(INIT));
        chk("lock_retry", 32'(RETRY_CNT), 32'd0);

        // Lock chatter
        PLL_LOCK = 1'b0;
        do_reset();
        for (int i = 0; i < 20 && PLL_RESETB !== 1'b1; i++) tick();
        chk("chatter_start", 32'(PLL_RESETB), 32'd1);
        PLL_LOCK = 1'($urandom_range(0, 1));
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && PLL_RESETB === 1'b1; i++) begin
            if (i % 5 == 4) PLL_LOCK = ~PLL_LOCK;
            tick();
            cnt++;
            if (READY === 1'b1) seen = 1'b1;
        end
        chk("chatter_timeout", 32'(cnt), 32'(LT));
        chk("chatter_retry", 32'(RETRY_CNT), 32'd1);
        chk("chatter_no_ready", 32'(seen), 32'd0);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (PLL_RESETB === 1'b1) break;
            cnt++;
        end
        chk("retry_hold_len", 32'(cnt), 32'(RC));

        // Exhaust retries
        PLL_LOCK = 1'b0;
        for (int i = 0; i < 100 && FAULT !== 1'b1; i++) tick();
        chk("exhaust_fault", 32'(FAULT), 32'd1);
        chk("exhaust_retry", 32'(RETRY_CNT), 32'd2);
        chk("exhaust_resetb", 32'(PLL_RESETB), 32'd0);
        DELAY_VAL = 8'($urandom);
        DELAY_REQ = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DELAY_ACK === 1'b1 || PLL_RESETB !== 1'b0) seen = 1'b1;
        end
        chk("fault_no_ack_resetb_low", 32'(seen), 32'd0);
        chk("fault_sticky", 32'(FAULT), 32'd1);
        DELAY_REQ = 1'b0;
        do_reset();
        chk("fault_cleared", 32'(FAULT), 32'd0);
        chk("fault_retry_cleared", 32'(RETRY_CNT), 32'd0);

        // Delay change
        PLL_LOCK = 1'b1;
        wait_ready("dly_pre_ready", 40, 1'b1);
        DELAY_VAL = 8'hA3;
        DELAY_REQ = 1'b1;
        tick();
        chk("dly_ack", 32'(DELAY_ACK), 32'd1);
        chk("dly_value", 32'(PLL_DELAY), 32'hA3);
        chk("dly_ready_low", 32'(READY), 32'd0);
        tick();
        chk("dly_ack_one_cycle", 32'(DELAY_ACK), 32'd0);
        cnt  = 1;
        seen = (PLL_RESETB !== 1'b1);
        for (int i = 0; i < 40 && READY !== 1'b1; i++) begin
            tick();
            cnt++;
            if (PLL_RESETB !== 1'b1) seen = 1'b1;
        end
        chk("dly_ack_to_ready", 32'(cnt), 32'd10);
        chk("dly_resetb_high", 32'(seen), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (DELAY_ACK === 1'b1) seen = 1'b1;
        end
        chk("dly_no_rearm", 32'(seen), 32'd0);
        DELAY_REQ = 1'b0;
        tick();
        v         = 8'($urandom);
        DELAY_VAL = v;
        DELAY_REQ = 1'b1;
        tick();
        chk("dly_rearm_ack", 32'(DELAY_ACK), 32'd1);
        chk("dly_rearm_value", 32'(PLL_DELAY), 32'(v));
        DELAY_REQ = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_ready("dly_rand_ready", 40, 1'b1);
            repeat ($urandom_range(0, 5)) tick();
            v         = 8'($urandom);
            DELAY_VAL = v;
            DELAY_REQ = 1'b1;
            tick();
            chk("dly_rand_ack", 32'(DELAY_ACK), 32'd1);
            chk("dly_rand_value", 32'(PLL_DELAY), 32'(v));
            DELAY_REQ = 1'b0;
        end

        // Lock loss in RUN
        wait_ready("loss_pre_ready", 40, 1'b1);
        PLL_LOCK = 1'b0;
        tick();
        chk("loss_t1_ready", 32'(READY), 32'd1);
        PLL_LOCK = 1'b1;
        tick();
        chk("loss_t2_ready", 32'(READY), 32'd1);
        tick();
        chk("loss_t3_ready", 32'(READY), 32'd0);
        chk("loss_count", 32'(LOSS_CNT), 32'd1);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (PLL_RESETB === 1'b1) break;
            cnt++;
        end
        chk("loss_hold_len", 32'(cnt), 32'(RC));
        wait_ready("loss_relock", 40, 1'b1);
        for (int k = 0; k < 300; k++) begin
            PLL_LOCK = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            PLL_LOCK = 1'b1;
            wait_ready("loss_loop_drop", 10, 1'b0);
            wait_ready("loss_loop_relock", 40, 1'b1);
        end
        chk("loss_saturate", 32'(LOSS_CNT), 32'd255);

        // Lock loss coincident with a request
        PLL_LOCK = 1'b0;
        tick();
        PLL_LOCK = 1'b1;
        tick();
        v         = 8'($urandom);
        DELAY_VAL = v;
        DELAY_REQ = 1'b1;
        tick();
        chk("simul_hold", 32'(PLL_RESETB), 32'd0);
        chk("simul_no_ack", 32'(DELAY_ACK), 32'd0);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && DELAY_ACK !== 1'b1; i++) begin
            tick();
            cnt++;
            if (READY === 1'b1) seen = 1'b1;
        end
        chk("simul_ack_latency", 32'(cnt), 32'd13);
        chk("simul_value", 32'(PLL_DELAY), 32'(v));
        chk("simul_no_ready", 32'(seen), 32'd0);

        // Reset during APPLY
        RESET = 1'b1;
        #1;
        check_reset_vals("apply_rst");
        check_all();
        DELAY_REQ = 1'b0;
        tick();
        RESET = 1'b0;

        // Randomized soak
        for (int i = 0; i < 600; i++) begin
            if ((i / 150) % 2 == 1) PLL_LOCK = 1'($urandom_range(0, 1));
            else                    PLL_LOCK = ($urandom_range(0, 15) != 0);
            if (DELAY_REQ == 1'b0) begin
                if ($urandom_range(0, 7) == 0) begin
                    DELAY_VAL = 8'($urandom);
                    DELAY_REQ = 1'b1;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                DELAY_REQ = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
